// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store misalignment sequencer.
// Optional feature macro used by the sequencer: MISALIGN_TRAP_EN.
package lsu_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Bytes are always aligned; halves need addr[0]==0; words need addr[1:0]==0
  function automatic logic is_aligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    case (func3[1:0])
      2'b01:   is_aligned = (addr_lo[0] == 1'b0);
      2'b10:   is_aligned = (addr_lo == 2'b00);
      default: is_aligned = 1'b1;
    endcase
  endfunction

  // Loads reject 011/110/111; stores accept only 000/001/010
  function automatic logic is_illegal(input logic we, input logic [2:0] func3);
    if (we) is_illegal = !(func3 == SB || func3 == SH || func3 == SW);
    else    is_illegal = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of an assembled load word according to funct3.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_data,
  output logic [31:0] o_data_c
);

  // Extend from bit 7 or 15, or pass the full word through
  always_comb begin
    o_data_c = i_data;
    case (i_func3)
      LB:      o_data_c = {{24{i_data[7]}}, i_data[7:0]};
      LH:      o_data_c = {{16{i_data[15]}}, i_data[15:0]};
      LBU:     o_data_c = {24'b0, i_data[7:0]};
      LHU:     o_data_c = {16'b0, i_data[15:0]};
      default: o_data_c = i_data;
    endcase
  end

endmodule

// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer: issues aligned accesses directly and splits
// misaligned half/word accesses into byte accesses.
// Define MISALIGN_TRAP_EN to reject misaligned requests with rsp_err instead.
module lsu_misalign_seq
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              d_wr_en,
  output logic [ADDR_W-1:0] dAddr,
  output logic [31:0]       dWdata,
  output logic [2:0]        d_func3,
  input  logic [31:0]       dRdata
);

  lsu_state_t        r_state, w_state;
  logic              r_we, w_we;
  logic [2:0]        r_func3, w_func3;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0]       r_wdata, w_wdata;
  logic              r_split, w_split;
  logic [1:0]        r_cnt, w_cnt;
  logic [1:0]        r_last, w_last;
  logic [31:0]       r_asm, w_asm, w_asm_nx, w_ext;
  logic              r_req_ready, w_req_ready;
  logic              r_rsp_valid, w_rsp_valid;
  logic [31:0]       r_rsp_rdata, w_rsp_rdata;
  logic              r_rsp_err, w_rsp_err;
  logic              r_busy, w_busy;
  logic              r_d_wr_en, w_d_wr_en;
  logic [ADDR_W-1:0] r_d_addr, w_d_addr;
  logic [31:0]       r_d_wdata, w_d_wdata;
  logic [2:0]        r_d_func3, w_d_func3;
  logic              w_aligned, w_illegal, w_trap;

  assign w_aligned = is_aligned(req_func3, req_addr[1:0]);
  assign w_illegal = is_illegal(req_we, req_func3);

  // Misaligned requests either trap or get split
`ifdef MISALIGN_TRAP_EN
  assign w_trap = !w_aligned;
`else
  assign w_trap = 1'b0;
`endif

  // Merge the byte (or full word) returned by the current access into the assembly
  always_comb begin
    w_asm_nx = r_asm;
    if (r_state == ACCESS && !r_we) begin
      if (r_split) w_asm_nx[{r_cnt, 3'b000} +: 8] = dRdata[7:0];
      else         w_asm_nx = dRdata;
    end
  end

  lsu_load_ext u_load_ext (
    .i_func3  (r_func3),
    .i_data   (w_asm_nx),
    .o_data_c (w_ext)
  );

  // Next-state and next-output logic; memory outputs are set up one cycle ahead
  always_comb begin
    w_state     = r_state;
    w_we        = r_we;
    w_func3     = r_func3;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_split     = r_split;
    w_cnt       = r_cnt;
    w_last      = r_last;
    w_asm       = w_asm_nx;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = 32'b0;
    w_rsp_err   = 1'b0;
    w_d_wr_en   = 1'b0;
    w_d_func3   = LW;
    w_d_addr    = r_d_addr;
    w_d_wdata   = r_d_wdata;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_we    = req_we;
          w_func3 = req_func3;
          w_addr  = req_addr;
          w_wdata = req_wdata;
          w_cnt   = 2'd0;
          w_asm   = 32'b0;
          if (w_illegal || w_trap) begin
            w_state     = RESP;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
          end else begin
            w_state   = ACCESS;
            w_split   = !w_aligned;
            w_last    = w_aligned ? 2'd0 : ((req_func3[1:0] == 2'b10) ? 2'd3 : 2'd1);
            w_d_addr  = req_addr;
            w_d_wr_en = req_we;
            if (w_aligned) begin
              w_d_func3 = req_func3;
              w_d_wdata = req_wdata;
            end else begin
              w_d_func3 = req_we ? SB : LBU;
              w_d_wdata = {24'b0, req_wdata[7:0]};
            end
          end
        end
      end
      ACCESS: begin
        if (r_cnt == r_last) begin
          w_state     = RESP;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_we ? 32'b0 : (r_split ? w_ext : w_asm_nx);
        end else begin
          w_cnt     = r_cnt + 2'd1;
          w_d_addr  = r_addr + ADDR_W'(w_cnt);
          w_d_wr_en = r_we;
          w_d_func3 = r_we ? SB : LBU;
          w_d_wdata = {24'b0, r_wdata[{w_cnt, 3'b000} +: 8]};
        end
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
    w_req_ready = (w_state == IDLE);
    w_busy      = (w_state != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_func3     <= LW;
      r_addr      <= '0;
      r_wdata     <= 32'b0;
      r_split     <= 1'b0;
      r_cnt       <= 2'd0;
      r_last      <= 2'd0;
      r_asm       <= 32'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_d_wr_en   <= 1'b0;
      r_d_addr    <= '0;
      r_d_wdata   <= 32'b0;
      r_d_func3   <= LW;
    end else begin
      r_state     <= w_state;
      r_we        <= w_we;
      r_func3     <= w_func3;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_split     <= w_split;
      r_cnt       <= w_cnt;
      r_last      <= w_last;
      r_asm       <= w_asm;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_busy      <= w_busy;
      r_d_wr_en   <= w_d_wr_en;
      r_d_addr    <= w_d_addr;
      r_d_wdata   <= w_d_wdata;
      r_d_func3   <= w_d_func3;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign d_wr_en   = r_d_wr_en;
  assign dAddr     = r_d_addr;
  assign dWdata    = r_d_wdata;
  assign d_func3   = r_d_func3;

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Directed self-checking bench for lsu_misalign_seq with a 64-byte memory model.
// Honours MISALIGN_TRAP_EN to select trap or split expectations.
module tb_lsu_misalign_seq;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_err, busy, d_wr_en;
  logic [31:0]       rsp_rdata, dWdata, dRdata;
  logic [ADDR_W-1:0] dAddr;
  logic [2:0]        d_func3;

  logic [7:0] mem [0:63];
  logic       tb_preload;
  logic [7:0] m_b0, m_b1, m_b2, m_b3;

  int n_checks = 0;
  int n_fail   = 0;

  // Trace of one transaction
  int          tr_n, tr_lat;
  logic [31:0] tr_addr  [8];
  logic [7:0]  tr_wbyte [8];
  logic [2:0]  tr_f3    [8];
  logic        tr_we    [8];
  logic [31:0] tr_rdata;
  logic        tr_err, tr_wr_seen, tr_rsp_next;

  lsu_misalign_seq #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .d_wr_en(d_wr_en), .dAddr(dAddr), .dWdata(dWdata), .d_func3(d_func3),
    .dRdata(dRdata)
  );

  always #5 clk = ~clk;

  // Combinational little-endian read port
  assign m_b0 = mem[dAddr[5:0]];
  assign m_b1 = mem[dAddr[5:0] + 6'd1];
  assign m_b2 = mem[dAddr[5:0] + 6'd2];
  assign m_b3 = mem[dAddr[5:0] + 6'd3];

  always_comb begin
    case (d_func3)
      3'b000:  dRdata = {{24{m_b0[7]}}, m_b0};
      3'b001:  dRdata = {{16{m_b1[7]}}, m_b1, m_b0};
      3'b100:  dRdata = {24'b0, m_b0};
      3'b101:  dRdata = {16'b0, m_b1, m_b0};
      default: dRdata = {m_b3, m_b2, m_b1, m_b0};
    endcase
  end

  // Preload (byte a = 0x80|a) or synchronous write
  always @(posedge clk) begin
    if (tb_preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h80 | 8'(i);
    end else if (d_wr_en) begin
      mem[dAddr[5:0]] <= dWdata[7:0];
      if (d_func3[1:0] != 2'b00) mem[dAddr[5:0] + 6'd1] <= dWdata[15:8];
      if (d_func3[1:0] == 2'b10) begin
        mem[dAddr[5:0] + 6'd2] <= dWdata[23:16];
        mem[dAddr[5:0] + 6'd3] <= dWdata[31:24];
      end
    end
  end

  // Issue one request, record ACCESS cycles until the response (bounded)
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    int guard = 0;
    int cyc;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_func3 = 3'b111;
    req_addr = 32'h0000_0030; req_wdata = 32'h5A5A_5A5A;
    tr_n = 0; tr_wr_seen = 1'b0; tr_lat = -1; tr_rdata = 32'hx; tr_err = 1'bx;
    cyc = 1;
    while (cyc <= 12) begin
      if (d_wr_en) tr_wr_seen = 1'b1;
      if (rsp_valid) begin
        tr_lat = cyc; tr_rdata = rsp_rdata; tr_err = rsp_err;
        break;
      end
      if (tr_n < 8) begin
        tr_addr[tr_n] = dAddr; tr_wbyte[tr_n] = dWdata[7:0];
        tr_f3[tr_n] = d_func3; tr_we[tr_n] = d_wr_en;
      end
      tr_n++;
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
    tr_rsp_next = rsp_valid;
  endtask

  task automatic test_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (d_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_d_wr_en got %b want 0", d_wr_en); end
    n_checks++; if (dAddr !== 32'h0) begin n_fail++; $display("FAIL reset_dAddr got %h want 0", dAddr); end
    n_checks++; if (dWdata !== 32'h0) begin n_fail++; $display("FAIL reset_dWdata got %h want 0", dWdata); end
    n_checks++; if (d_func3 !== 3'b010) begin n_fail++; $display("FAIL reset_d_func3 got %b want 010", d_func3); end
  endtask

  task automatic test_aligned();
    run_req(1'b0, 3'b100, 32'h2, 32'h0);
    n_checks++; if (tr_lat !== 2) begin n_fail++; $display("FAIL lbu_latency got %0d want 2", tr_lat); end
    n_checks++; if (tr_n !== 1) begin n_fail++; $display("FAIL lbu_accesses got %0d want 1", tr_n); end
    n_checks++; if (tr_f3[0] !== 3'b100) begin n_fail++; $display("FAIL lbu_func3 got %b want 100", tr_f3[0]); end
    n_checks++; if (tr_rdata !== 32'h0000_0082) begin n_fail++; $display("FAIL lbu_rdata got %h want 00000082", tr_rdata); end
    n_checks++; if (tr_err !== 1'b0) begin n_fail++; $display("FAIL lbu_err got %b want 0", tr_err); end
    n_checks++; if (tr_rsp_next !== 1'b0) begin n_fail++; $display("FAIL lbu_pulse got %b want 0", tr_rsp_next); end
    run_req(1'b0, 3'b010, 32'h4, 32'h0);
    n_checks++; if (tr_rdata !== 32'h8786_8584) begin n_fail++; $display("FAIL lw4_rdata got %h want 87868584", tr_rdata); end
    n_checks++; if (tr_err !== 1'b0) begin n_fail++; $display("FAIL lw4_err got %b want 0", tr_err); end
    run_req(1'b0, 3'b001, 32'h2, 32'h0);
    n_checks++; if (tr_rdata !== 32'hFFFF_8382) begin n_fail++; $display("FAIL lh2_rdata got %h want ffff8382", tr_rdata); end
    n_checks++; if (tr_f3[0] !== 3'b001) begin n_fail++; $display("FAIL lh2_func3 got %b want 001", tr_f3[0]); end
  endtask

  task automatic test_split_load();
    run_req(1'b0, 3'b010, 32'h1, 32'h0);
    n_checks++; if (tr_lat !== 5) begin n_fail++; $display("FAIL lw1_latency got %0d want 5", tr_lat); end
    n_checks++; if (tr_n !== 4) begin n_fail++; $display("FAIL lw1_accesses got %0d want 4", tr_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (tr_addr[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL lw1_addr%0d got %h want %h", i, tr_addr[i], i + 1); end
      n_checks++; if (tr_f3[i] !== 3'b100 || tr_we[i] !== 1'b0) begin n_fail++; $display("FAIL lw1_func3_%0d got %b/%b want 100/0", i, tr_f3[i], tr_we[i]); end
    end
    n_checks++; if (tr_rdata !== 32'h8483_8281) begin n_fail++; $display("FAIL lw1_rdata got %h want 84838281", tr_rdata); end
    run_req(1'b0, 3'b001, 32'h3, 32'h0);
    n_checks++; if (tr_lat !== 3) begin n_fail++; $display("FAIL lh3_latency got %0d want 3", tr_lat); end
    n_checks++; if (tr_addr[0] !== 32'h3 || tr_addr[1] !== 32'h4) begin n_fail++; $display("FAIL lh3_addr got %h,%h want 3,4", tr_addr[0], tr_addr[1]); end
    n_checks++; if (tr_rdata !== 32'hFFFF_8483) begin n_fail++; $display("FAIL lh3_rdata got %h want ffff8483", tr_rdata); end
    run_req(1'b0, 3'b101, 32'h3, 32'h0);
    n_checks++; if (tr_rdata !== 32'h0000_8483) begin n_fail++; $display("FAIL lhu3_rdata got %h want 00008483", tr_rdata); end
    // Address wrap across 2^ADDR_W
    run_req(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0);
    n_checks++; if (tr_addr[1] !== 32'h0 || tr_addr[3] !== 32'h2) begin n_fail++; $display("FAIL wrap_addr got %h,%h want 0,2", tr_addr[1], tr_addr[3]); end
    n_checks++; if (tr_rdata !== 32'h8281_80BF) begin n_fail++; $display("FAIL wrap_rdata got %h want 828180bf", tr_rdata); end
  endtask

  task automatic test_split_store();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    run_req(1'b1, 3'b010, 32'h6, 32'hDEAD_BEEF);
    n_checks++; if (tr_lat !== 5 || tr_n !== 4) begin n_fail++; $display("FAIL sw6_timing got lat=%0d n=%0d want 5/4", tr_lat, tr_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tr_wbyte[i] !== exp_b[i] || tr_f3[i] !== 3'b000 || tr_we[i] !== 1'b1 || tr_addr[i] !== 32'(6 + i)) begin
        n_fail++;
        $display("FAIL sw6_byte%0d got %h f3=%b we=%b a=%h want %h 000 1 %h", i, tr_wbyte[i], tr_f3[i], tr_we[i], tr_addr[i], exp_b[i], 6 + i);
      end
    end
    n_checks++; if (tr_rdata !== 32'h0 || tr_err !== 1'b0) begin n_fail++; $display("FAIL sw6_rsp got %h/%b want 0/0", tr_rdata, tr_err); end
    run_req(1'b0, 3'b010, 32'h4, 32'h0);
    n_checks++; if (tr_rdata !== 32'hBEEF_8584) begin n_fail++; $display("FAIL sw6_lw4 got %h want beef8584", tr_rdata); end
    run_req(1'b0, 3'b010, 32'h8, 32'h0);
    n_checks++; if (tr_rdata !== 32'h8B8A_DEAD) begin n_fail++; $display("FAIL sw6_lw8 got %h want 8b8adead", tr_rdata); end
  endtask

  task automatic test_trap();
    run_req(1'b0, 3'b010, 32'h1, 32'h0);
    n_checks++; if (tr_lat !== 1 || tr_n !== 0) begin n_fail++; $display("FAIL trap_timing got lat=%0d n=%0d want 1/0", tr_lat, tr_n); end
    n_checks++; if (tr_err !== 1'b1 || tr_rdata !== 32'h0) begin n_fail++; $display("FAIL trap_rsp got %b/%h want 1/0", tr_err, tr_rdata); end
    run_req(1'b1, 3'b001, 32'h5, 32'h1234);
    n_checks++; if (tr_err !== 1'b1 || tr_wr_seen !== 1'b0) begin n_fail++; $display("FAIL trap_sh got err=%b wr=%b want 1/0", tr_err, tr_wr_seen); end
    run_req(1'b0, 3'b010, 32'h4, 32'h0);
    n_checks++; if (tr_rdata !== 32'h8786_8584 || tr_err !== 1'b0) begin n_fail++; $display("FAIL trap_lw4 got %h/%b want 87868584/0", tr_rdata, tr_err); end
  endtask

  task automatic test_illegal();
    run_req(1'b0, 3'b011, 32'h4, 32'h0);
    n_checks++; if (tr_lat !== 1) begin n_fail++; $display("FAIL ill_ld_latency got %0d want 1", tr_lat); end
    n_checks++; if (tr_err !== 1'b1 || tr_rdata !== 32'h0) begin n_fail++; $display("FAIL ill_ld_rsp got %b/%h want 1/0", tr_err, tr_rdata); end
    n_checks++; if (tr_wr_seen !== 1'b0 || tr_n !== 0) begin n_fail++; $display("FAIL ill_ld_access got wr=%b n=%0d want 0/0", tr_wr_seen, tr_n); end
    run_req(1'b1, 3'b100, 32'h10, 32'h55);
    n_checks++; if (tr_err !== 1'b1 || tr_wr_seen !== 1'b0) begin n_fail++; $display("FAIL ill_st got err=%b wr=%b want 1/0", tr_err, tr_wr_seen); end
    n_checks++; if (mem[16] !== 8'h90) begin n_fail++; $display("FAIL ill_st_mem got %h want 90", mem[16]); end
  endtask

  task automatic test_reset_mid();
    logic saw = 1'b0;
    tb_preload = 1'b1; @(posedge clk); #1; tb_preload = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h6; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (dAddr !== 32'h6 || dWdata !== 32'h44 || d_wr_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_acc0 got %h/%h/%b want 6/44/1", dAddr, dWdata, d_wr_en); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || d_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async got rdy=%b busy=%b we=%b want 1/0/0", req_ready, busy, d_wr_en); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (rsp_valid) saw = 1'b1; end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rsp got %b want 0", saw); end
    n_checks++; if (mem[6] !== 8'h44 || mem[7] !== 8'h33) begin n_fail++; $display("FAIL rst_mid_written got %h,%h want 44,33", mem[6], mem[7]); end
    n_checks++; if (mem[8] !== 8'h88 || mem[9] !== 8'h89) begin n_fail++; $display("FAIL rst_mid_untouched got %h,%h want 88,89", mem[8], mem[9]); end
  endtask

  task automatic test_back_to_back();
    int n_rsp = 0;
    int first = -1;
    int second = -1;
    logic bad_ready = 1'b0;
    logic [31:0] last_rd = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b100; req_addr = 32'h5; req_wdata = 32'h0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (busy && req_ready) bad_ready = 1'b1;
      if (rsp_valid) begin
        if (n_rsp == 0) first = i;
        if (n_rsp == 1) second = i;
        n_rsp++; last_rd = rsp_rdata;
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (n_rsp !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", n_rsp); end
    n_checks++; if (first !== 2 || second !== 5) begin n_fail++; $display("FAIL b2b_spacing got %0d,%0d want 2,5", first, second); end
    n_checks++; if (last_rd !== 32'h85 || bad_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_data got %h rdy_err=%b want 85/0", last_rd, bad_ready); end
  endtask

  initial begin
    reset = 1'b1; tb_preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000; req_addr = '0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    tb_preload = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    test_aligned();
    test_illegal();
`ifdef MISALIGN_TRAP_EN
    test_trap();
`else
    test_split_load();
    test_split_store();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout reached without summary");
    $fatal(1);
  end

endmodule
